// File: rtl/bcd_string_tx.sv
// bcd_string_tx: latches a packed BCD word and streams it as ASCII bytes over valid/ready, MSD first, optional CR+LF.
// Define BCD_STRING_TX_LZ_BLANK_EN to send leading zeros as spaces.
module bcd_string_tx #(
  parameter int NDIGITS  = 4,
  parameter int SEND_EOL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd,
  output logic                   busy,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   done
);
  localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  typedef enum logic [2:0] {IDLE, DIGIT, CR, LF, DONE} state_t;
  state_t state;
  logic [4*NDIGITS-1:0] shadow;
  logic [IW-1:0] idx, nxt_idx;
  logic [3:0] msd, nxt_dig;
  logic [7:0] msd_chr, nxt_chr;
  logic hs;
  function automatic logic [7:0] asc(input logic [3:0] d);
    return d > 4'd9 ? 8'h3F : {4'h3, d};
  endfunction
  assign hs      = tx_valid && tx_ready;
  assign nxt_idx = idx - 1'b1;
  assign msd     = bcd[4*NDIGITS-1 -: 4];
  assign nxt_dig = shadow[4*nxt_idx +: 4];
`ifdef BCD_STRING_TX_LZ_BLANK_EN
  // lz: every digit sent so far in this frame was a zero
  logic lz;
  assign msd_chr = (NDIGITS > 1 && msd == 4'd0) ? 8'h20 : asc(msd);
  assign nxt_chr = (lz && nxt_idx != '0 && nxt_dig == 4'd0) ? 8'h20 : asc(nxt_dig);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lz <= 1'b0;
    else if (state == IDLE && start) lz <= msd == 4'd0;
    else if (state == DIGIT && hs && idx != '0) lz <= lz && nxt_dig == 4'd0;
`else
  assign msd_chr = asc(msd);
  assign nxt_chr = asc(nxt_dig);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shadow   <= bcd;
          idx      <= IW'(NDIGITS - 1);
          busy     <= 1'b1;
          tx_valid <= 1'b1;
          tx_data  <= msd_chr;
          state    <= DIGIT;
        end
        DIGIT: if (hs) begin
          if (idx != '0) begin
            idx     <= nxt_idx;
            tx_data <= nxt_chr;
          end else if (SEND_EOL != 0) begin
            tx_data <= 8'h0D;
            state   <= CR;
          end else begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        CR: if (hs) begin
          tx_data <= 8'h0A;
          state   <= LF;
        end
        LF: if (hs) begin
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_string_tx.sv
// tb_bcd_string_tx: directed table of frames on two instances (with and without CR+LF).
module tb_bcd_string_tx;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, tx_ready = 1'b0, sel = 1'b1;
  logic [15:0] bcd = '0;
  logic busy1, valid1, done1, busy0, valid0, done0;
  logic [7:0] data1, data0;
  logic d_busy, d_valid, d_done;
  logic [7:0] d_data;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bcd_string_tx #(.NDIGITS(4), .SEND_EOL(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .bcd(bcd), .busy(busy1),
    .tx_data(data1), .tx_valid(valid1), .tx_ready(tx_ready), .done(done1));
  bcd_string_tx #(.NDIGITS(4), .SEND_EOL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .bcd(bcd), .busy(busy0),
    .tx_data(data0), .tx_valid(valid0), .tx_ready(tx_ready), .done(done0));

  assign d_busy  = sel ? busy1  : busy0;
  assign d_valid = sel ? valid1 : valid0;
  assign d_done  = sel ? done1  : done0;
  assign d_data  = sel ? data1  : data0;

  typedef struct {
    logic [15:0] v;
    bit          e;
    bit          rnd;
    bit          inj;
    logic [47:0] x;
    int          len;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t t);
    int cyc, n;
    bit stall;
    logic [7:0] pd;
    bcd = t.v; sel = t.e; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; n = 0; stall = 1'b0; pd = '0;
    chk("first_valid", 32'(d_valid), 1);
    chk("first_busy", 32'(d_busy), 1);
    while (!d_done && cyc < 200) begin
      if (stall) begin
        chk("hold_data", 32'(d_data), 32'(pd));
        chk("hold_valid", 32'(d_valid), 1);
      end
      if (t.inj && cyc == 3) begin start = 1'b1; bcd = 16'h9999; end
      tx_ready = t.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (d_valid && tx_ready) begin
        if (n < 6) chk($sformatf("byte%0d", n), 32'(d_data), 32'(t.x[47-8*n -: 8]));
        n++;
      end
      stall = d_valid && !tx_ready;
      pd = d_data;
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    chk("done_seen", 32'(d_done), 1);
    chk("byte_count", 32'(n), 32'(t.len));
    chk("busy_at_done", 32'(d_busy), 1);
    chk("valid_at_done", 32'(d_valid), 0);
    if (!t.rnd) chk("done_cycle", 32'(cyc), 32'(t.len + 1));
    if (t.inj) begin start = 1'b1; bcd = 16'h5555; end
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", 32'(d_busy), 0);
    chk("idle_done", 32'(d_done), 0);
    chk("idle_valid", 32'(d_valid), 0);
  endtask

  initial begin
    tv[0] = '{16'h1234, 1'b1, 1'b0, 1'b0, 48'h313233340D0A, 6};
    tv[1] = '{16'h1234, 1'b1, 1'b1, 1'b0, 48'h313233340D0A, 6};
    tv[2] = '{16'h9A0F, 1'b0, 1'b0, 1'b0, 48'h393F303F0000, 4};
    tv[3] = '{16'h1234, 1'b1, 1'b0, 1'b1, 48'h313233340D0A, 6};
`ifdef BCD_STRING_TX_LZ_BLANK_EN
    tv[4] = '{16'h0042, 1'b1, 1'b0, 1'b0, 48'h202034320D0A, 6};
    tv[5] = '{16'h0000, 1'b1, 1'b0, 1'b0, 48'h202020300D0A, 6};
    tv[6] = '{16'h0A05, 1'b1, 1'b0, 1'b0, 48'h203F30350D0A, 6};
`else
    tv[4] = '{16'h0042, 1'b1, 1'b0, 1'b0, 48'h303034320D0A, 6};
    tv[5] = '{16'h0000, 1'b1, 1'b0, 1'b0, 48'h303030300D0A, 6};
    tv[6] = '{16'h0A05, 1'b1, 1'b0, 1'b0, 48'h303F30350D0A, 6};
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_valid", 32'(valid1), 0);
    chk("rst_data", 32'(data1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_valid0", 32'(valid0), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run(tv[i]);
    // abort after two accepted bytes
    sel = 1'b1; bcd = 16'h1234; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy1), 0);
    chk("arst_valid", 32'(valid1), 0);
    chk("arst_data", 32'(data1), 0);
    chk("arst_done", 32'(done1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(valid1), 0);
      chk("post_rst_busy", 32'(busy1), 0);
    end
    run(tv[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_string_tx.md
Name: bcd_string_tx

Overview:
- Parametrised multi-digit BCD-to-ASCII serializer that feeds the UART transmitter.
- Latches an NDIGITS-wide packed BCD word on a start pulse and emits one ASCII byte per valid/ready handshake, most significant digit first.
- Optionally appends CR+LF after the digits.
- Sits between the counter/BCD-conversion logic and the UART TX, replacing per-digit combinational lookup plus external sequencing.

Parameters:
- NDIGITS, 4: number of BCD digits per frame; legal range 1..16.
- SEND_EOL, 1: 1 = append 0x0D then 0x0A after the last digit; 0 = no terminator.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle request to send a frame; sampled only in IDLE.
- bcd, input, 4*NDIGITS: packed BCD; digit k occupies bits [4k+3:4k]; digit NDIGITS-1 is the MSD.
- busy, output, 1: high from the cycle after an accepted start until the done pulse, inclusive.
- tx_data, output, 8: ASCII byte offered to the UART.
- tx_valid, output, 1: tx_data is valid.
- tx_ready, input, 1: UART accepts the byte.
- done, output, 1: one-cycle pulse after the last byte of the frame is accepted.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All of the following go to 0: busy, tx_valid, tx_data, done, and the digit index.
  - FSM goes to IDLE; any partial frame is abandoned.
  - Nothing resumes after rst_n is released.
- FSM states: IDLE, DIGIT, CR, LF, DONE.
- IDLE:
  - start=1 latches bcd into an internal shadow register and loads index = NDIGITS-1.
  - Next state is DIGIT. busy=1 and tx_valid=1 from the next cycle.
  - Latency from start to the first tx_valid is 1 cycle.
- DIGIT:
  - tx_data = ASCII of shadow digit[index].
  - Digit value 0..9 maps to 0x30+value; 10..15 maps to 0x3F ('?').
  - On tx_valid&&tx_ready:
    - index>0: decrement index and stay in DIGIT.
    - index==0: go to CR if SEND_EOL=1, else go to DONE.
- CR: tx_data=0x0D; on handshake go to LF.
- LF: tx_data=0x0A; on handshake go to DONE.
- DONE:
  - tx_valid=0, done=1, busy=1 for exactly one cycle, then go to IDLE with busy=0.
  - A new start is accepted in the following cycle.
- Handshake rules:
  - tx_data and tx_valid are registered.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable; tx_valid never drops before its handshake.
  - With tx_ready held at 1, bytes go out on consecutive cycles.
- Frame lengths and timing:
  - Frame length is NDIGITS + 2*SEND_EOL bytes.
  - With continuous ready, done asserts NDIGITS + 2*SEND_EOL + 1 cycles after the start cycle.
- start outside IDLE, including the DONE cycle, is ignored.
- Changes to bcd after the start cycle do not affect the frame in progress.
- tx_ready while tx_valid=0 is ignored.

Optional Feature:
- Macro: BCD_STRING_TX_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Each leading 0 digit is sent as 0x20 (space), up to the first nonzero digit.
  - The least significant digit is never blanked.
  - Invalid digits (10..15) count as nonzero and stop blanking.
  - Frame length and timing are unchanged.
- Undefined: all digits are sent as-is, and no blanking logic is present in the RTL.

Test Plan:
- NDIGITS=4, SEND_EOL=1, bcd=0x1234, tx_ready=1 -> bytes 31 32 33 34 0D 0A on 6 consecutive cycles starting 1 cycle after start; done pulses at cycle 7.
- Same frame with tx_ready toggled pseudo-randomly -> identical byte sequence; tx_data stable during every stall; one done pulse.
- bcd=0x9A0F, SEND_EOL=0 -> 39 3F 30 3F, then done; no 0D/0A emitted.
- Second start pulsed mid-frame and on the DONE cycle -> ignored, single frame; a start on the cycle after done is accepted.
- rst_n driven low after 2 bytes accepted -> outputs 0 immediately (asynchronous); after release, no byte appears until a new start.
- With BCD_STRING_TX_LZ_BLANK_EN defined:
  - bcd=0x0042 -> 20 20 34 32 0D 0A.
  - bcd=0x0000 -> 20 20 20 30 0D 0A.
  - bcd=0x0A05 -> 20 3F 30 35 0D 0A.
